fetch_unit: RTL and testbench

//  Front-end stage directly upstream of instruction memory: owns the program counter, drives the

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_next_pc_sel.sv | 35 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: state encoding,
// the halt marker word and the sequential PC increment.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;
   localparam int          PC_STEP   = 4;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, instruction memory (pc_out/instr_in) and
// decode (valid/ready buffer handshake).
interface fetch_unit_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] pc_out;
   logic [DATA_W-1:0] instr_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output pc_out,
      input  instr_in,
      output out_valid,
      input  out_ready,
      output instr_out,
      output instr_pc
   );

   modport slave (
      input  pc_out,
      output instr_in,
      input  out_valid,
      output out_ready,
      input  instr_out,
      input  instr_pc
   );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: jump, then taken branch, then sequential step, else hold.
// Redirect targets are forced to word alignment.
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              enable,
   input  logic              advance,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              redirect,
   output logic [ADDR_W-1:0] next_pc
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

   always_comb begin
      redirect = enable & (jump | branch_taken);
      next_pc  = pc;
      if (enable && jump) begin
         next_pc = jump_target & ALIGN_MASK;
      end else if (enable && branch_taken) begin
         next_pc = branch_target & ALIGN_MASK;
      end else if (advance) begin
         // Wraps naturally modulo 2^ADDR_W.
         next_pc = pc + STEP;
      end
   end

endmodule : next_pc_sel

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers the returned word into a one-entry buffer handed to decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W       = 7,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter bit                HALT_ON_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   fetch_unit_if.master      bus,
   input  logic              stall,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              halted_q, halted_d;

   logic in_run;
   logic redirect;
   logic would_fire;
   logic halt_hit;
   logic capture;

   assign in_run = (state_q == ST_RUN);

   next_pc_sel #(
      .ADDR_W(ADDR_W)
   ) u_next_pc_sel (
      .pc           (pc_q),
      .enable       (in_run),
      .advance      (capture),
      .jump         (jump),
      .jump_target  (jump_target),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .redirect     (redirect),
      .next_pc      (pc_d)
   );

   // A halt word found on a would-fire cycle is never buffered.
   always_comb begin
      would_fire = in_run & ~stall & ~redirect & (~valid_q | bus.out_ready);
      halt_hit   = would_fire & HALT_ON_ZERO & (bus.instr_in == DATA_W'(HALT_WORD));
      capture    = would_fire & ~halt_hit;
   end

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;

      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (halt_hit) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      // A redirect flushes the buffer even if decode is taking it this cycle.
      if (redirect) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
         instr_d = bus.instr_in;
         ipc_d   = pc_q;
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         ipc_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         halted_q <= halted_d;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.out_valid = valid_q;
   assign bus.instr_out = instr_q;
   assign bus.instr_pc  = ipc_q;
   assign halted        = halted_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked each cycle against
// a behavioural model of the fetch rules.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall;
   logic       jump;
   logic [6:0] jump_target;
   logic       branch_taken;
   logic [6:0] branch_target;
   logic       halted;

   logic [31:0] mem [32];

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [6:0]  m_pc;
   logic [6:0]  m_ipc;
   logic [31:0] m_instr;
   bit          m_valid;
   bit          m_halted;
   bit          m_started;

   localparam logic [31:0] WORD_A = 32'hA1A2_A3A4;
   localparam logic [31:0] WORD_B = 32'hB1B2_B3B4;
   localparam logic [31:0] WORD_C = 32'hC1C2_C3C4;

   fetch_unit_if #(.ADDR_W(7), .DATA_W(32)) bus ();

   fetch_unit #(
      .ADDR_W      (7),
      .DATA_W      (32),
      .RESET_PC    (7'd0),
      .HALT_ON_ZERO(1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .stall        (stall),
      .jump         (jump),
      .jump_target  (jump_target),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   assign bus.instr_in = mem[bus.pc_out[6:2]];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc      = 7'd0;
      m_ipc     = 7'd0;
      m_instr   = 32'd0;
      m_valid   = 1'b0;
      m_halted  = 1'b0;
      m_started = 1'b0;
   endtask

   // One clock of fetch behaviour from the current inputs.
   task automatic model_step();
      logic [31:0] word;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (!m_halted) begin
         if (jump) begin
            m_pc    = {jump_target[6:2], 2'b00};
            m_valid = 1'b0;
         end else if (branch_taken) begin
            m_pc    = {branch_target[6:2], 2'b00};
            m_valid = 1'b0;
         end else if (!stall && (!m_valid || bus.out_ready)) begin
            word = mem[m_pc >> 2];
            if (word == 32'd0) begin
               m_halted = 1'b1;
               m_valid  = 1'b0;
            end else begin
               m_instr = word;
               m_ipc   = m_pc;
               m_valid = 1'b1;
               m_pc    = 7'((int'(m_pc) + 4) % 128);
            end
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".pc_out"},    32'(bus.pc_out),    32'(m_pc));
      check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      check_val({tag, ".halted"},    32'(halted),        32'(m_halted));
      check_val({tag, ".instr_out"}, bus.instr_out,      m_instr);
      check_val({tag, ".instr_pc"},  32'(bus.instr_pc),  32'(m_ipc));
   endtask

   task automatic step_cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic clear_ctrl();
      stall         = 1'b0;
      jump          = 1'b0;
      branch_taken  = 1'b0;
      jump_target   = 7'd0;
      branch_target = 7'd0;
   endtask

   initial begin
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      clear_ctrl();
      for (int i = 0; i < 32; i++) mem[i] = $urandom | 32'h1;
      mem[0] = WORD_A;
      mem[1] = WORD_B;
      mem[2] = WORD_C;
      mem[3] = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all("reset");
      reset = 1'b1;

      // Sequential fetch A, B, C after one IDLE cycle
      step_cycle("idle");
      check_val("idle_no_valid", 32'(bus.out_valid), 32'd0);
      step_cycle("seq0");
      check_val("seq0_instr", bus.instr_out, WORD_A);
      step_cycle("seq1");
      check_val("seq1_instr", bus.instr_out, WORD_B);
      check_val("seq1_pc", 32'(bus.instr_pc), 32'd4);

      // Backpressure holds buffer and PC
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_cycle("bp");
         check_val("bp_instr", bus.instr_out, WORD_B);
         check_val("bp_pcout", 32'(bus.pc_out), 32'd8);
      end
      bus.out_ready = 1'b1;
      step_cycle("bp_resume");
      check_val("resume_instr", bus.instr_out, WORD_C);
      check_val("resume_ipc", 32'(bus.instr_pc), 32'd8);

      // Jump beats branch, target aligned, buffer flushed
      jump = 1'b1; jump_target = 7'h21;
      branch_taken = 1'b1; branch_target = 7'h10;
      step_cycle("jump");
      check_val("jump_pc", 32'(bus.pc_out), 32'h20);
      check_val("jump_flush", 32'(bus.out_valid), 32'd0);
      clear_ctrl();

      // PC wrap at the top of the address space, then stall
      jump = 1'b1; jump_target = 7'd120;
      step_cycle("j120");
      clear_ctrl();
      step_cycle("f120");
      step_cycle("f124");
      check_val("wrap_pc", 32'(bus.pc_out), 32'd0);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step_cycle("stall");
         check_val("stall_pc", 32'(bus.pc_out), 32'd0);
      end
      stall = 1'b0;

      // Halt on the zero word at address 12
      for (int i = 0; i < 4; i++) step_cycle("to_halt");
      check_val("halt_flag", 32'(halted), 32'd1);
      check_val("halt_pc", 32'(bus.pc_out), 32'd12);
      jump = 1'b1; jump_target = 7'h40;
      branch_taken = 1'b1; branch_target = 7'h50;
      for (int i = 0; i < 3; i++) begin
         stall = i[0];
         step_cycle("halted");
         check_val("halted_pc", 32'(bus.pc_out), 32'd12);
         check_val("halted_valid", 32'(bus.out_valid), 32'd0);
      end
      clear_ctrl();

      // Asynchronous reset while a word is buffered
      reset = 1'b0;
      #1;
      model_reset();
      check_all("rst_halt");
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      step_cycle("r_idle");
      step_cycle("r_fire");
      step_cycle("r_hold");
      check_val("pre_async_valid", 32'(bus.out_valid), 32'd1);
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      check_val("async_valid", 32'(bus.out_valid), 32'd0);
      check_val("async_pc", 32'(bus.pc_out), 32'd0);
      check_val("async_instr", bus.instr_out, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Randomized phase
      for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'd0 : ($urandom | 32'h1);
      for (int n = 0; n < 800; n++) begin
         if (m_halted && $urandom_range(0, 3) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_all("rand_rst");
            for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'd0 : ($urandom | 32'h1);
            @(posedge clk);
            #1;
            reset = 1'b1;
         end else begin
            stall         = ($urandom_range(0, 4) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump_target   = 7'($urandom);
            branch_target = 7'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step_cycle("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_fetch_unit
